multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle MIPS control unit: the issuing side of the ALU interface. Decodes opcode/funct from the instruction register, sequences each instruction through a state machine, drives the 4-bit ALU operation code, operand selects and all datapath write/memory strobes, and samples the ALU `zero` flag for branches. Sits between instruction register, memory port and ALU in the multi-cycle datapath.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset; one clock, `clk`
- `opcode`  in  6  instr[31:26] from instruction register
- `funct`  in  6  instr[5:0]
- `zero`  in  1  ALU equality flag (first == second operand)
- `memReady`  in  1  memory completes current read/write this cycle
- `aluControlInput`  out  4  ALU op: 0000 and, 0001 or, 0010 add, 0011 sll, 0100 srl, 0110 sub, 0111 slt, 1011 sltu
- `aluSrcA`  out  1  0 = PC, 1 = register A
- `aluSrcB`  out  2  00 = register B, 01 = constant 4, 10 = extended imm, 11 = sign-ext imm << 2
- `zeroExt`  out  1  imm extender zero-extends (andi/ori) instead of sign-extending
- `pcSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A
- `pcWrite`  out  1  PC load strobe
- `irWrite`, `memRead`, `memWrite`, `iOrD`, `regWrite`, `regDst`, `memToReg`  out  1 each  standard datapath controls (iOrD 1 = ALUOut address; regDst 1 = rd; memToReg 1 = MDR)
- `illegalOp`  out  1  one-cycle pulse on undecodable instruction

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BRANCH, JUMP, JR. State register only; outputs decoded combinationally from state (+ `memReady`, `zero` where noted). Unlisted outputs are 0.
- FETCH: memRead=1, iOrD=0, aluSrcA=0, aluSrcB=01, ALU add; when memReady: irWrite=1, pcWrite=1, pcSource=00, -> DECODE; else hold.
- DECODE: aluSrcA=0, aluSrcB=11, ALU add (branch target into ALUOut). Next: lw/sw (100011/101011) -> MEMADR; R (000000) -> JR if funct 001000, else REXEC; beq 000100 -> BRANCH; j 000010 -> JUMP; addi/andi/ori/slti/sltiu (001000/001100/001101/001010/001011) -> IEXEC; anything else -> illegalOp=1, -> FETCH.
- Undefined R funct: illegalOp=1 in DECODE, -> FETCH. Legal funct: add/addu 10000x -> 0010, sub/subu 10001x -> 0110, and 100100 -> 0000, or 100101 -> 0001, slt 101010 -> 0111, sltu 101011 -> 1011, sll 000000 -> 0011, srl 000010 -> 0100.
- MEMADR: aluSrcA=1, aluSrcB=10, add; -> MEMRD (lw) / MEMWR (sw).
- MEMRD: memRead=1, iOrD=1; memReady -> MEMWB. MEMWB: regWrite=1, regDst=0, memToReg=1 -> FETCH.
- MEMWR: memWrite=1, iOrD=1; memReady -> FETCH.
- REXEC: aluSrcA=1, aluSrcB=00, funct op -> RWB. RWB: regWrite=1, regDst=1 (funct op held) -> FETCH.
- IEXEC: aluSrcA=1, aluSrcB=10; addi 0010, andi 0000 + zeroExt, ori 0001 + zeroExt, slti 0111, sltiu 1011 -> IWB. IWB: regWrite=1, regDst=0, same op/zeroExt -> FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, sub, pcSource=01, pcWrite=zero -> FETCH.
- JUMP: pcSource=10, pcWrite=1 -> FETCH. JR: pcSource=11, pcWrite=1 -> FETCH.
- `opcode`/`funct` are sampled every cycle from the IR; IR is stable after FETCH, so no local latch.

## Timing
- Reset: at next edge state = FETCH. While `reset` high all strobes (pcWrite, irWrite, memRead, memWrite, regWrite, illegalOp) forced 0; selects show FETCH values (aluControlInput=0010, aluSrcB=01, others 0). Reset mid-instruction abandons it; no partial write completes after the reset edge.
- Cycles with memReady=1 throughout: branch/j/jr 3, R-type/I-type/sw 4, lw 5. Each memReady=0 cycle in FETCH/MEMRD/MEMWR adds one.
- memReady is ignored outside FETCH/MEMRD/MEMWR. memWrite held steady until memReady.
- pcWrite in BRANCH follows `zero` combinationally in that same cycle.

## Configuration
- `MULTICYCLE_CTRL_BNE_EN` defined: opcode 000101 (bne) decodes -> BRANCH with pcWrite = !zero. Undefined: bne is illegal (illegalOp pulse in DECODE, -> FETCH, 2 cycles).

## Test plan
- Reset held 3 cycles mid-MEMWR -> all strobes 0 during reset, state FETCH after, memWrite never re-asserts for the abandoned sw.
- add (opcode 0, funct 100000), memReady=1 -> 4 cycles; REXEC/RWB aluControlInput=0010, RWB regWrite=1 regDst=1.
- lw with memReady low 2 cycles in MEMRD -> 7 cycles total; regWrite=1 memToReg=1 exactly once.
- beq with zero=1 -> pcWrite=1 pcSource=01 in BRANCH; zero=0 -> pcWrite=0; both 3 cycles.
- ori -> IEXEC/IWB aluControlInput=0001, zeroExt=1; sltiu -> 1011, zeroExt=0.
- opcode 111111 and R funct 111111 -> illegalOp one cycle, back to FETCH; bne with and without MULTICYCLE_CTRL_BNE_EN (zero=0 -> pcWrite=1 vs illegalOp=1).

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: sequences each instruction through a state machine and drives
// ALU op, operand selects and datapath strobes. Define MULTICYCLE_CTRL_BNE_EN to decode bne.
`timescale 1ns/1ps
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       memReady,
   output logic [3:0] aluControlInput,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic       zeroExt,
   output logic [1:0] pcSource,
   output logic       pcWrite,
   output logic       irWrite,
   output logic       memRead,
   output logic       memWrite,
   output logic       iOrD,
   output logic       regWrite,
   output logic       regDst,
   output logic       memToReg,
   output logic       illegalOp
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REXEC,
      S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JR
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   state_t     state_reg, state_next;
   logic       r_legal, i_zext, dec_legal, br_taken;
   logic [3:0] r_alu, i_alu;

   always_comb begin
      r_legal = 1'b1;
      r_alu   = ALU_ADD;
      case (funct)
         6'b100000, 6'b100001: r_alu = 4'b0010;
         6'b100010, 6'b100011: r_alu = 4'b0110;
         6'b100100:            r_alu = 4'b0000;
         6'b100101:            r_alu = 4'b0001;
         6'b101010:            r_alu = 4'b0111;
         6'b101011:            r_alu = 4'b1011;
         6'b000000:            r_alu = 4'b0011;
         6'b000010:            r_alu = 4'b0100;
         6'b001000:            r_alu = ALU_ADD;  // jr: ALU unused
         default:              r_legal = 1'b0;
      endcase
   end

   always_comb begin
      i_alu  = ALU_ADD;
      i_zext = 1'b0;
      case (opcode)
         6'b001100: begin i_alu = 4'b0000; i_zext = 1'b1; end
         6'b001101: begin i_alu = 4'b0001; i_zext = 1'b1; end
         6'b001010: i_alu = 4'b0111;
         6'b001011: i_alu = 4'b1011;
         default:   i_alu = ALU_ADD;
      endcase
   end

   always_comb begin
      dec_legal = 1'b0;
      case (opcode)
         6'b100011, 6'b101011, 6'b000100, 6'b000010,
         6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001011: dec_legal = 1'b1;
         6'b000000: dec_legal = r_legal;
`ifdef MULTICYCLE_CTRL_BNE_EN
         6'b000101: dec_legal = 1'b1;
`endif
         default:   dec_legal = 1'b0;
      endcase
   end

   always_comb begin
      br_taken = zero;
`ifdef MULTICYCLE_CTRL_BNE_EN
      if (opcode == 6'b000101)
         br_taken = !zero;
`endif
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_FETCH:  if (memReady) state_next = S_DECODE;
         S_DECODE: begin
            state_next = S_FETCH;
            case (opcode)
               6'b100011, 6'b101011: state_next = S_MEMADR;
               6'b000000:
                  if (funct == 6'b001000) state_next = S_JR;
                  else if (r_legal)       state_next = S_REXEC;
               6'b000100: state_next = S_BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
               6'b000101: state_next = S_BRANCH;
`endif
               6'b000010: state_next = S_JUMP;
               6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001011: state_next = S_IEXEC;
               default:   state_next = S_FETCH;
            endcase
         end
         S_MEMADR: state_next = (opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (memReady) state_next = S_MEMWB;
         S_MEMWR:  if (memReady) state_next = S_FETCH;
         S_REXEC:  state_next = S_RWB;
         S_IEXEC:  state_next = S_IWB;
         default:  state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= S_FETCH;
      else       state_reg <= state_next;
   end

   // Reset overrides the decode so an abandoned instruction cannot strobe anything.
   always_comb begin
      aluControlInput = 4'b0000;
      aluSrcA  = 1'b0;
      aluSrcB  = 2'b00;
      zeroExt  = 1'b0;
      pcSource = 2'b00;
      pcWrite  = 1'b0;
      irWrite  = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      iOrD     = 1'b0;
      regWrite = 1'b0;
      regDst   = 1'b0;
      memToReg = 1'b0;
      illegalOp = 1'b0;
      if (reset) begin
         aluControlInput = ALU_ADD;
         aluSrcB = 2'b01;
      end else begin
         case (state_reg)
            S_FETCH: begin
               memRead = 1'b1;
               aluSrcB = 2'b01;
               aluControlInput = ALU_ADD;
               irWrite = memReady;
               pcWrite = memReady;
            end
            S_DECODE: begin
               aluSrcB = 2'b11;
               aluControlInput = ALU_ADD;
               illegalOp = !dec_legal;
            end
            S_MEMADR: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
               aluControlInput = ALU_ADD;
            end
            S_MEMRD: begin
               memRead = 1'b1;
               iOrD = 1'b1;
            end
            S_MEMWB: begin
               regWrite = 1'b1;
               memToReg = 1'b1;
            end
            S_MEMWR: begin
               memWrite = 1'b1;
               iOrD = 1'b1;
            end
            S_REXEC: begin
               aluSrcA = 1'b1;
               aluControlInput = r_alu;
            end
            S_RWB: begin
               aluControlInput = r_alu;
               regWrite = 1'b1;
               regDst = 1'b1;
            end
            S_IEXEC: begin
               aluSrcA = 1'b1;
               aluSrcB = 2'b10;
               aluControlInput = i_alu;
               zeroExt = i_zext;
            end
            S_IWB: begin
               aluControlInput = i_alu;
               zeroExt = i_zext;
               regWrite = 1'b1;
            end
            S_BRANCH: begin
               aluSrcA = 1'b1;
               aluControlInput = ALU_SUB;
               pcSource = 2'b01;
               pcWrite = br_taken;
            end
            S_JUMP: begin
               pcSource = 2'b10;
               pcWrite = 1'b1;
            end
            S_JR: begin
               pcSource = 2'b11;
               pcWrite = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle and
// compares the full output vector against hand-computed values.
`timescale 1ns/1ps
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset, zero, memReady;
   logic [5:0] opcode, funct;
   logic [3:0] aluControlInput;
   logic       aluSrcA, zeroExt, pcWrite, irWrite, memRead, memWrite, iOrD;
   logic       regWrite, regDst, memToReg, illegalOp;
   logic [1:0] aluSrcB, pcSource;
   logic [18:0] obs;

   int vectors = 0;
   int miscompares = 0;

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .memReady(memReady), .aluControlInput(aluControlInput), .aluSrcA(aluSrcA),
      .aluSrcB(aluSrcB), .zeroExt(zeroExt), .pcSource(pcSource), .pcWrite(pcWrite),
      .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite), .iOrD(iOrD),
      .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg), .illegalOp(illegalOp)
   );

   always #5 clk = ~clk;

   // {alu, srcA, srcB, zeroExt, pcSource, pcW, irW, memRd, memWr, iOrD, regW, regDst, memToReg, illegal}
   assign obs = {aluControlInput, aluSrcA, aluSrcB, zeroExt, pcSource, pcWrite, irWrite,
                 memRead, memWrite, iOrD, regWrite, regDst, memToReg, illegalOp};

   localparam logic [18:0] E_RST    = {4'b0010, 1'b0, 2'b01, 1'b0, 2'b00, 9'b000000000};
   localparam logic [18:0] E_FETCH  = {4'b0010, 1'b0, 2'b01, 1'b0, 2'b00, 9'b111000000};
   localparam logic [18:0] E_FWAIT  = {4'b0010, 1'b0, 2'b01, 1'b0, 2'b00, 9'b001000000};
   localparam logic [18:0] E_DEC    = {4'b0010, 1'b0, 2'b11, 1'b0, 2'b00, 9'b000000000};
   localparam logic [18:0] E_DECILL = {4'b0010, 1'b0, 2'b11, 1'b0, 2'b00, 9'b000000001};
   localparam logic [18:0] E_MEMADR = {4'b0010, 1'b1, 2'b10, 1'b0, 2'b00, 9'b000000000};
   localparam logic [18:0] E_MEMRD  = {4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 9'b001010000};
   localparam logic [18:0] E_MEMWB  = {4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 9'b000001010};
   localparam logic [18:0] E_MEMWR  = {4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 9'b000110000};
   localparam logic [18:0] E_BR_T   = {4'b0110, 1'b1, 2'b00, 1'b0, 2'b01, 9'b100000000};
   localparam logic [18:0] E_BR_N   = {4'b0110, 1'b1, 2'b00, 1'b0, 2'b01, 9'b000000000};

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [18:0] e);
      #1;
      vectors++;
      assert (obs === e) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, e);
      end
   endtask

   initial begin
      reset = 1'b1; memReady = 1'b1; zero = 1'b0; opcode = 6'd0; funct = 6'd0;
      nxt(); chk("reset_a", E_RST);
      nxt(); chk("reset_b", E_RST);
      reset = 1'b0;

      // add, no wait states: 4 cycles
      opcode = 6'b000000; funct = 6'b100000;
      chk("add_fetch", E_FETCH); nxt();
      chk("add_decode", E_DEC); nxt();
      chk("add_rexec", {4'b0010, 1'b1, 2'b00, 1'b0, 2'b00, 9'b000000000}); nxt();
      chk("add_rwb", {4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 9'b000001100}); nxt();

      // lw with two MEMRD wait cycles: 7 cycles
      opcode = 6'b100011; funct = 6'd0;
      chk("lw_fetch", E_FETCH); nxt();
      chk("lw_decode", E_DEC); nxt();
      chk("lw_memadr", E_MEMADR); nxt();
      memReady = 1'b0;
      chk("lw_memrd_w1", E_MEMRD); nxt();
      chk("lw_memrd_w2", E_MEMRD); nxt();
      memReady = 1'b1;
      chk("lw_memrd", E_MEMRD); nxt();
      chk("lw_memwb", E_MEMWB); nxt();

      // beq taken, then zero drops within the same BRANCH cycle
      opcode = 6'b000100; zero = 1'b1;
      chk("beq1_fetch", E_FETCH); nxt();
      chk("beq1_decode", E_DEC); nxt();
      chk("beq1_branch", E_BR_T);
      zero = 1'b0;
      chk("beq1_branch_zdrop", E_BR_N); nxt();

      // beq not taken
      chk("beq0_fetch", E_FETCH); nxt();
      chk("beq0_decode", E_DEC); nxt();
      chk("beq0_branch", E_BR_N); nxt();

      // ori
      opcode = 6'b001101;
      chk("ori_fetch", E_FETCH); nxt();
      chk("ori_decode", E_DEC); nxt();
      chk("ori_iexec", {4'b0001, 1'b1, 2'b10, 1'b1, 2'b00, 9'b000000000}); nxt();
      chk("ori_iwb", {4'b0001, 1'b0, 2'b00, 1'b1, 2'b00, 9'b000001000}); nxt();

      // sltiu
      opcode = 6'b001011;
      chk("sltiu_fetch", E_FETCH); nxt();
      chk("sltiu_decode", E_DEC); nxt();
      chk("sltiu_iexec", {4'b1011, 1'b1, 2'b10, 1'b0, 2'b00, 9'b000000000}); nxt();
      chk("sltiu_iwb", {4'b1011, 1'b0, 2'b00, 1'b0, 2'b00, 9'b000001000}); nxt();

      // j and jr
      opcode = 6'b000010;
      chk("j_fetch", E_FETCH); nxt();
      chk("j_decode", E_DEC); nxt();
      chk("j_jump", {4'b0000, 1'b0, 2'b00, 1'b0, 2'b10, 9'b100000000}); nxt();
      opcode = 6'b000000; funct = 6'b001000;
      chk("jr_fetch", E_FETCH); nxt();
      chk("jr_decode", E_DEC); nxt();
      chk("jr_jr", {4'b0000, 1'b0, 2'b00, 1'b0, 2'b11, 9'b100000000}); nxt();

      // illegal opcode, then a stalled FETCH proves the return
      opcode = 6'b111111; funct = 6'd0;
      chk("badop_fetch", E_FETCH); nxt();
      chk("badop_decode", E_DECILL); nxt();
      memReady = 1'b0;
      chk("badop_refetch", E_FWAIT); nxt();
      memReady = 1'b1;

      // illegal R funct
      opcode = 6'b000000; funct = 6'b111111;
      chk("badfn_fetch", E_FETCH); nxt();
      chk("badfn_decode", E_DECILL); nxt();
      memReady = 1'b0;
      chk("badfn_refetch", E_FWAIT); nxt();
      memReady = 1'b1;

      // bne with zero=0
      opcode = 6'b000101; funct = 6'd0; zero = 1'b0;
      chk("bne_fetch", E_FETCH); nxt();
`ifdef MULTICYCLE_CTRL_BNE_EN
      chk("bne_decode", E_DEC); nxt();
      chk("bne_branch", E_BR_T); nxt();
`else
      chk("bne_decode", E_DECILL); nxt();
      memReady = 1'b0;
      chk("bne_refetch", E_FWAIT); nxt();
      memReady = 1'b1;
`endif

      // sw stalled in MEMWR, then reset for 3 cycles abandons it
      opcode = 6'b101011;
      chk("sw_fetch", E_FETCH); nxt();
      chk("sw_decode", E_DEC); nxt();
      chk("sw_memadr", E_MEMADR); nxt();
      memReady = 1'b0;
      chk("sw_memwr_a", E_MEMWR); nxt();
      chk("sw_memwr_b", E_MEMWR); nxt();
      reset = 1'b1;
      chk("sw_reset_1", E_RST); nxt();
      chk("sw_reset_2", E_RST); nxt();
      chk("sw_reset_3", E_RST); nxt();
      reset = 1'b0;
      chk("post_reset_fetch_a", E_FWAIT); nxt();
      chk("post_reset_fetch_b", E_FWAIT);
      memReady = 1'b1;
      chk("post_reset_fetch_rdy", E_FETCH); nxt();
      chk("post_reset_decode", E_DEC); nxt();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
